// File: rtl/alu_seq_pkg.sv
// Shared types for the alu operation sequencer: FSM states, opcode width and instruction layout.
// The instruction struct uses the default data and register-file sizing.
package alu_seq_pkg;

  localparam int OPC_W     = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREGS = 4;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [DEF_AW-1:0]    rd;
    logic [DEF_AW-1:0]    ra;
    logic [DEF_AW-1:0]    rb;
    logic                 imm_en;
    logic [DEF_WIDTH-1:0] imm;
    logic                 load;
    logic                 use_carry;
  } instr_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction channel into the sequencer: valid/ready handshake plus decoded instruction fields.
// The master is the instruction source; the slave is the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
);
  import alu_seq_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPC_W-1:0]     instr_opcode;
  logic [AW-1:0]        instr_rd;
  logic [AW-1:0]        instr_ra;
  logic [AW-1:0]        instr_rb;
  logic                 instr_imm_en;
  logic [WIDTH-1:0]     instr_imm;
  logic                 instr_load;
  logic                 instr_use_carry;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
           instr_imm_en, instr_imm, instr_load, instr_use_carry,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
           instr_imm_en, instr_imm, instr_load, instr_use_carry,
    output instr_ready
  );

endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, three combinational read ports.
// Reads during a write edge return the pre-write contents; async active-low clear.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    ra_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [AW-1:0]    rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o,
  input  logic [AW-1:0]    dbg_addr_i,
  output logic [WIDTH-1:0] dbg_data_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one instruction at a time into an external alu: operands held ALU_LAT cycles, then y
// committed to rd with flags; result pulses ALU_LAT+1 cycles after accept (1 for loads), ready only in IDLE.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_op_sequencer_if.slave        instr,
  output logic [OPC_W-1:0]         alu_opcode,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [WIDTH-1:0]         alu_cin,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_cout,
  input  logic                     alu_overflow,
  input  logic                     alu_negative,
  input  logic                     alu_zero,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     flag_c,
  output logic                     flag_v,
  output logic                     flag_n,
  output logic                     flag_z,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW    = $clog2(NREGS);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_t           state_q;
  logic [AW-1:0]    rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OPC_W-1:0] alu_opcode_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] alu_cin_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_valid_q;
  logic             flag_c_q;
  logic             flag_v_q;
  logic             flag_n_q;
  logic             flag_z_q;

  logic             accept;
  logic             commit;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;

  // Held low while reset is asserted so nothing is offered acceptance during reset.
  assign instr.instr_ready = rst_n && (state_q == IDLE);
  assign accept            = instr.instr_valid && instr.instr_ready;
  assign commit            = (state_q == EXEC) && (cnt_q == CNT_W'(1));

  // Loads write at accept, alu ops at commit; both cannot happen on the same edge.
  assign rf_we    = (accept && instr.instr_load) || commit;
  assign rf_waddr = commit ? rd_q  : instr.instr_rd;
  assign rf_wdata = commit ? alu_y : instr.instr_imm;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .ra_addr_i  (instr.instr_ra),
    .ra_data_o  (rf_a),
    .rb_addr_i  (instr.instr_rb),
    .rb_data_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q <= instr.instr_rd;
            if (instr.instr_load) begin
              res_data_q  <= instr.instr_imm;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              alu_opcode_q <= instr.instr_opcode;
              alu_a_q      <= rf_a;
              alu_b_q      <= instr.instr_imm_en ? instr.instr_imm : rf_b;
              alu_cin_q    <= WIDTH'(instr.instr_use_carry & flag_c_q);
              cnt_q        <= CNT_W'(ALU_LAT);
              state_q      <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (commit) begin
            res_data_q  <= alu_y;
            flag_c_q    <= alu_cout;
            flag_v_q    <= alu_overflow;
            flag_n_q    <= alu_negative;
            flag_z_q    <= alu_zero;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign flag_c     = flag_c_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;
  assign flag_z     = flag_z_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=3, each fed by an
// adder stub whose result is only valid after the configured latency; results checked via scoreboards.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam logic [3:0] OPC_ADD = 4'h3;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] flags;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst3_n;

  alu_op_sequencer_if #(.WIDTH(W), .NREGS(N)) if1 ();
  alu_op_sequencer_if #(.WIDTH(W), .NREGS(N)) if3 ();

  logic [3:0]    a1_op, a1_a, a1_b, a1_cin, a1_y;
  logic          a1_c, a1_v, a1_n, a1_z, r1_vld;
  logic [3:0]    r1_dat, f1, d1_dat;
  logic [AW-1:0] d1_addr;

  logic [3:0]    a3_op, a3_a, a3_b, a3_cin, a3_y;
  logic          a3_c, a3_v, a3_n, a3_z, r3_vld;
  logic [3:0]    r3_dat, f3, d3_dat;
  logic [AW-1:0] d3_addr;

  int checks = 0;
  int errors = 0;

  exp_t       q1[$];
  exp_t       q3[$];
  logic [3:0] m_regs [2][4];
  logic [3:0] m_flags [2];

  // {y, c, v, n, z}
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] cin);
    logic [4:0] s;
    logic [3:0] y;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin[0]};
    y = s[3:0];
    return {y, s[4], (a[3] == b[3]) && (y[3] != a[3]), y[3], (y == 4'h0)};
  endfunction

  assign {a1_y, a1_c, a1_v, a1_n, a1_z} = alu_f(a1_a, a1_b, a1_cin);

  logic [7:0] p3_0, p3_1, p3_2;
  assign p3_0 = alu_f(a3_a, a3_b, a3_cin);
  always @(posedge clk) begin
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign {a3_y, a3_c, a3_v, a3_n, a3_z} = p3_2;

  alu_op_sequencer #(.WIDTH(W), .NREGS(N), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr(if1),
    .alu_opcode(a1_op), .alu_a(a1_a), .alu_b(a1_b), .alu_cin(a1_cin),
    .alu_y(a1_y), .alu_cout(a1_c), .alu_overflow(a1_v), .alu_negative(a1_n), .alu_zero(a1_z),
    .res_valid(r1_vld), .res_data(r1_dat),
    .flag_c(f1[3]), .flag_v(f1[2]), .flag_n(f1[1]), .flag_z(f1[0]),
    .dbg_addr(d1_addr), .dbg_data(d1_dat)
  );

  alu_op_sequencer #(.WIDTH(W), .NREGS(N), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .instr(if3),
    .alu_opcode(a3_op), .alu_a(a3_a), .alu_b(a3_b), .alu_cin(a3_cin),
    .alu_y(a3_y), .alu_cout(a3_c), .alu_overflow(a3_v), .alu_negative(a3_n), .alu_zero(a3_z),
    .res_valid(r3_vld), .res_data(r3_dat),
    .flag_c(f3[3]), .flag_v(f3[2]), .flag_n(f3[1]), .flag_z(f3[0]),
    .dbg_addr(d3_addr), .dbg_data(d3_dat)
  );

  exp_t e1, e3;
  always @(negedge clk) begin
    if (r1_vld === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_spurious res_valid with res_data=%h, no result expected", r1_dat);
      end else begin
        e1 = q1.pop_front();
        if ({r1_dat, f1} !== {e1.data, e1.flags}) begin
          errors++;
          $display("FAIL sb1_result data/cvnz got %h/%b want %h/%b", r1_dat, f1, e1.data, e1.flags);
        end
      end
    end
    if (r3_vld === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL sb3_spurious res_valid with res_data=%h, no result expected", r3_dat);
      end else begin
        e3 = q3.pop_front();
        if ({r3_dat, f3} !== {e3.data, e3.flags}) begin
          errors++;
          $display("FAIL sb3_result data/cvnz got %h/%b want %h/%b", r3_dat, f3, e3.data, e3.flags);
        end
      end
    end
  end

  function automatic instr_t ld(input logic [1:0] rd, input logic [3:0] imm);
    instr_t t;
    t = '0;
    t.load = 1'b1;
    t.rd   = rd;
    t.imm  = imm;
    return t;
  endfunction

  function automatic instr_t op(input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                                input logic imm_en, input logic [3:0] imm, input logic uc);
    instr_t t;
    t = '0;
    t.opcode    = OPC_ADD;
    t.rd        = rd;
    t.ra        = ra;
    t.rb        = rb;
    t.imm_en    = imm_en;
    t.imm       = imm;
    t.use_carry = uc;
    return t;
  endfunction

  task automatic drive(input int s, input instr_t ins, input logic vld);
    if (s == 0) begin
      if1.instr_valid = vld; if1.instr_opcode = ins.opcode; if1.instr_rd = ins.rd;
      if1.instr_ra = ins.ra; if1.instr_rb = ins.rb; if1.instr_imm_en = ins.imm_en;
      if1.instr_imm = ins.imm; if1.instr_load = ins.load; if1.instr_use_carry = ins.use_carry;
    end else begin
      if3.instr_valid = vld; if3.instr_opcode = ins.opcode; if3.instr_rd = ins.rd;
      if3.instr_ra = ins.ra; if3.instr_rb = ins.rb; if3.instr_imm_en = ins.imm_en;
      if3.instr_imm = ins.imm; if3.instr_load = ins.load; if3.instr_use_carry = ins.use_carry;
    end
  endtask

  task automatic push_expect(input int s, input instr_t ins);
    exp_t       e;
    logic [3:0] bv;
    logic [7:0] r;
    if (ins.load) begin
      e.data  = ins.imm;
      e.flags = m_flags[s];
      m_regs[s][ins.rd] = ins.imm;
    end else begin
      bv = ins.imm_en ? ins.imm : m_regs[s][ins.rb];
      r  = alu_f(m_regs[s][ins.ra], bv, {3'b000, ins.use_carry & m_flags[s][3]});
      e.data  = r[7:4];
      e.flags = r[3:0];
      m_regs[s][ins.rd] = r[7:4];
      m_flags[s] = r[3:0];
    end
    if (s == 0) q1.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic send(input int s, input instr_t ins, output time t_acc);
    bit ok;
    push_expect(s, ins);
    @(negedge clk);
    drive(s, ins, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if ((s == 0 ? if1.instr_ready : if3.instr_ready) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout dut%0d instr_ready stayed 0, want 1", s);
    end
    @(posedge clk);
    t_acc = $time;
    #1 drive(s, ins, 1'b0);
  endtask

  // Returns the negedge index (1 = first after accept) on which res_valid was seen, 0 on timeout.
  task automatic wait_res(input int s, output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((s == 0 ? r1_vld : r3_vld) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      m_flags[s] = 4'h0;
      for (int r = 0; r < 4; r++) m_regs[s][r] = 4'h0;
    end
    #2;
    checks++;
    if ({if1.instr_ready, if3.instr_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready_low got %b want 00", {if1.instr_ready, if3.instr_ready});
    end
    checks++;
    if ({r1_vld, r1_dat, f1, a1_op, a1_a, a1_b, a1_cin} !== 25'h0) begin
      errors++;
      $display("FAIL rst_outputs1 got %h want 0", {r1_vld, r1_dat, f1, a1_op, a1_a, a1_b, a1_cin});
    end
    checks++;
    if ({r3_vld, r3_dat, f3, a3_op, a3_a, a3_b, a3_cin} !== 25'h0) begin
      errors++;
      $display("FAIL rst_outputs3 got %h want 0", {r3_vld, r3_dat, f3, a3_op, a3_a, a3_b, a3_cin});
    end
    @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    checks++;
    if ({if1.instr_ready, if3.instr_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rst_ready_high got %b want 11", {if1.instr_ready, if3.instr_ready});
    end
    for (int a = 0; a < N; a++) begin
      d1_addr = AW'(a);
      d3_addr = AW'(a);
      #1;
      checks++;
      if ({d1_dat, d3_dat} !== 8'h00) begin
        errors++;
        $display("FAIL rst_dbg r%0d got %h/%h want 0/0", a, d1_dat, d3_dat);
      end
    end
  endtask

  task automatic test_load_add;
    time t1, t2, t3;
    int  n;
    send(0, ld(2'd1, 4'h1), t1);
    wait_res(0, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL load_latency got %0d want 1", n); end
    send(0, ld(2'd2, 4'h1), t2);
    checks++;
    if (t2 - t1 !== 20) begin errors++; $display("FAIL load_throughput got %0t want 20", t2 - t1); end
    wait_res(0, n);
    send(0, op(2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 1'b0), t3);
    checks++;
    if (t3 - t2 !== 20) begin errors++; $display("FAIL load_to_op_spacing got %0t want 20", t3 - t2); end
    checks++;
    if ({a1_op, a1_a, a1_b, a1_cin} !== {OPC_ADD, 4'h1, 4'h1, 4'h0}) begin
      errors++;
      $display("FAIL add_alu_inputs got %h want %h", {a1_op, a1_a, a1_b, a1_cin}, {OPC_ADD, 4'h1, 4'h1, 4'h0});
    end
    wait_res(0, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", n); end
    checks++;
    if ({r1_dat, f1} !== {4'h2, 4'b0000}) begin
      errors++;
      $display("FAIL add_result data/cvnz got %h/%b want 2/0000", r1_dat, f1);
    end
    d1_addr = 2'd3;
    #1;
    checks++;
    if (d1_dat !== 4'h2) begin errors++; $display("FAIL add_dbg_r3 got %h want 2", d1_dat); end
  endtask

  task automatic test_carry;
    time t;
    int  n;
    send(0, ld(2'd0, 4'hF), t);
    wait_res(0, n);
    send(0, op(2'd0, 2'd0, 2'd0, 1'b1, 4'h1, 1'b0), t);
    wait_res(0, n);
    checks++;
    if ({r1_dat, f1} !== {4'h0, 4'b1001}) begin
      errors++;
      $display("FAIL wrap_result data/cvnz got %h/%b want 0/1001", r1_dat, f1);
    end
    send(0, op(2'd1, 2'd0, 2'd0, 1'b1, 4'h0, 1'b1), t);
    checks++;
    if ({a1_a, a1_b, a1_cin} !== {4'h0, 4'h0, 4'b0001}) begin
      errors++;
      $display("FAIL carry_in a/b/cin got %h want 001", {a1_a, a1_b, a1_cin});
    end
    wait_res(0, n);
    checks++;
    if ({r1_dat, f1} !== {4'h1, 4'b0000}) begin
      errors++;
      $display("FAIL carry_result data/cvnz got %h/%b want 1/0000", r1_dat, f1);
    end
  endtask

  task automatic test_overflow_hold;
    time    t;
    int     n;
    instr_t nxt;
    send(0, ld(2'd1, 4'h7), t);
    wait_res(0, n);
    send(0, op(2'd2, 2'd1, 2'd0, 1'b1, 4'h1, 1'b0), t);
    nxt = ld(2'd3, 4'hA);
    push_expect(0, nxt);
    drive(0, nxt, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (if1.instr_ready !== (i == 3)) begin
        errors++;
        $display("FAIL hold_ready cycle %0d got %b want %b", i, if1.instr_ready, (i == 3));
      end
      if (i == 2) begin
        checks++;
        if ({r1_vld, r1_dat, f1} !== {1'b1, 4'h8, 4'b0110}) begin
          errors++;
          $display("FAIL ovf_result vld/data/cvnz got %b/%h/%b want 1/8/0110", r1_vld, r1_dat, f1);
        end
      end
    end
    @(posedge clk);
    #1 drive(0, nxt, 1'b0);
    @(negedge clk);
    checks++;
    if ({r1_vld, r1_dat} !== {1'b1, 4'hA}) begin
      errors++;
      $display("FAIL held_load vld/data got %b/%h want 1/a", r1_vld, r1_dat);
    end
    d1_addr = 2'd2;
    #1;
    checks++;
    if (d1_dat !== 4'h8) begin errors++; $display("FAIL ovf_dbg_r2 got %h want 8", d1_dat); end
  endtask

  task automatic test_lat3;
    time t;
    int  n;
    send(1, ld(2'd1, 4'h5), t);
    wait_res(1, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL lat3_load_latency got %0d want 1", n); end
    send(1, op(2'd2, 2'd1, 2'd0, 1'b1, 4'h3, 1'b0), t);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a3_op, a3_a, a3_b, r3_vld} !== {OPC_ADD, 4'h5, 4'h3, (i == 4)}) begin
        errors++;
        $display("FAIL lat3_hold cycle %0d op/a/b/vld got %h/%h/%h/%b want 3/5/3/%b",
                 i, a3_op, a3_a, a3_b, r3_vld, (i == 4));
      end
    end
    checks++;
    if ({r3_dat, f3} !== {4'h8, 4'b0110}) begin
      errors++;
      $display("FAIL lat3_result data/cvnz got %h/%b want 8/0110", r3_dat, f3);
    end
  endtask

  task automatic test_reset_mid_exec;
    time t;
    bit  seen;
    send(1, op(2'd3, 2'd1, 2'd0, 1'b1, 4'h1, 1'b0), t);
    @(negedge clk);
    rst3_n = 1'b0;
    q3.delete();
    m_flags[1] = 4'h0;
    for (int r = 0; r < 4; r++) m_regs[1][r] = 4'h0;
    @(negedge clk);
    rst3_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r3_vld !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result got res_valid=1 want 0"); end
    checks++;
    if ({if3.instr_ready, r3_dat, f3} !== {1'b1, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL rst_mid_state ready/data/cvnz got %b/%h/%b want 1/0/0000", if3.instr_ready, r3_dat, f3);
    end
    for (int a = 1; a < N; a++) begin
      d3_addr = AW'(a);
      #1;
      checks++;
      if (d3_dat !== 4'h0) begin errors++; $display("FAIL rst_mid_dbg r%0d got %h want 0", a, d3_dat); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst3_n  = 1'b0;
    d1_addr = '0;
    d3_addr = '0;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    test_reset;
    test_load_add;
    test_carry;
    test_overflow_hold;
    test_lat3;
    test_reset_mid_exec;
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() + q3.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending results want 0", q1.size() + q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not complete within 100000 time units");
    $fatal(1, "bench stalled");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream control stage for the parameterised alu. Accepts one instruction at a time over a valid/ready handshake and reads its operands from a small internal register file.
- Drives the alu opcode/a/b/cin inputs from registers, waits a fixed alu latency, then writes alu y into the destination register and latches the C/V/N/Z flags.
- Lets a width-generic alu run real programs: chained arithmetic, carry propagation, flag inspection.

Parameters:
WIDTH, 4, data width of operands, registers and alu
NREGS, 4, register file depth (power of two, >=2)
ALU_LAT, 1, cycles alu_* inputs are held before y/flags are sampled (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instr_opcode  in  4  alu opcode, passed through opaque
instr_rd  in  $clog2(NREGS)  destination register
instr_ra  in  $clog2(NREGS)  operand a register
instr_rb  in  $clog2(NREGS)  operand b register
instr_imm_en  in  1  operand b = instr_imm instead of reg[rb]
instr_imm  in  WIDTH  immediate
instr_load  in  1  write instr_imm to rd directly, no alu use
instr_use_carry  in  1  alu cin = flag_c, else 0
alu_opcode  out  4  to alu
alu_a  out  WIDTH  to alu
alu_b  out  WIDTH  to alu
alu_cin  out  WIDTH  to alu; bit0 = carry, upper bits 0
alu_y  in  WIDTH  from alu
alu_cout, alu_overflow, alu_negative, alu_zero  in  1 each  from alu
res_valid  out  1  one-cycle pulse: result committed
res_data  out  WIDTH  committed value
flag_c, flag_v, flag_n, flag_z  out  1 each  architectural flags
dbg_addr  in  $clog2(NREGS)  debug read address
dbg_data  out  WIDTH  combinational reg[dbg_addr]

Behaviour:
- Reset (async on rst_n low): state IDLE, all registers 0, all flags 0, alu_* 0, res_valid 0, res_data 0. instr_ready is 1 once rst_n is high.
- The reset clears all state and drops any in-flight instruction; no res_valid is produced for it.
- FSM states: IDLE, EXEC, DONE. instr_ready = (state==IDLE), driven combinationally from state.
- Accept: instr_valid && instr_ready at a rising edge. All instr_* fields are latched on that edge. instr_valid while busy is ignored; the source must hold it.
- IDLE, accept with instr_load=1: reg[rd] <= instr_imm, res_data <= instr_imm, state -> DONE. Flags and alu_* are unchanged.
- IDLE, accept with instr_load=0, state -> EXEC with:
  - alu_opcode <= opcode
  - alu_a <= reg[ra]
  - alu_b <= imm_en ? imm : reg[rb]
  - alu_cin <= {0, use_carry ? flag_c : 0}
  - down-counter <= ALU_LAT
- Operand read uses pre-write register values; the ra==rb==rd aliasing is legal.
- EXEC: alu_* are held stable and the counter decrements each edge. On the edge where counter==1:
  - reg[rd] <= alu_y, res_data <= alu_y
  - flag_c/v/n/z <= alu_cout/overflow/negative/zero
  - state -> DONE
- DONE: res_valid=1 for exactly this cycle, then state -> IDLE. alu_* keep their last values.
- Latency, accept edge to res_valid: ALU_LAT+1 cycles for alu ops, 1 cycle for loads.
- Throughput: one instruction per ALU_LAT+2 cycles (alu op) or 2 cycles (load).
- Flags change only on alu-op commit. res_data holds its value until the next commit.
- dbg_data reflects a register write from the cycle after the commit edge.
- No width extension: alu_y is WIDTH bits and is written unmodified.

Decomposition:
- Package alu_seq_pkg holds:
  - state_t enum {IDLE, EXEC, DONE}
  - instr_t packed struct (opcode, rd, ra, rb, imm_en, imm, load, use_carry), parameterised widths via localparams
  - OPC_W=4
- Sub-module alu_regfile: NREGS x WIDTH, one synchronous write port, three combinational read ports (a, b, dbg), async active-low clear to 0.

Test Plan:
Bench uses a behavioural alu stub with y=a+b+cin[0], 4-bit, cout from bit 4, z=(y==0), n=y[3], v=signed overflow. Latency matches ALU_LAT.
- Reset with rst_n=0 -> all regs/flags/res_data 0 and instr_ready 0; after release instr_ready=1 and dbg_data=0 for every address.
- Load r1=0x1, then r2=0x1 -> res_valid one cycle each, 2 cycles per load. Alu op rd=r3, ra=r1, rb=r2 -> res_data=0x2 at accept+2 (ALU_LAT=1), flags C=0 V=0 N=0 Z=0.
- Load r0=0xF, then alu op rd=r0, ra=r0, imm_en imm=0x1 -> r0=0x0, C=1, Z=1. Next op use_carry: ra=r0, imm 0x0 -> alu_cin=0001, y=0x1, C=0.
- Signed overflow: r1=0x7 plus imm 0x1 -> y=0x8, V=1, N=1, C=0. Hold instr_valid during EXEC -> instr_ready=0 and no second accept until IDLE.
- ALU_LAT=3 build: alu_a/alu_b are held for 3 cycles and res_valid asserts exactly 4 cycles after accept. Assert rst_n=0 in the middle of EXEC -> no res_valid, rd is unchanged at 0, flags are 0.
